// File: rtl/instr_assembler_decoder_if.sv
// Byte-in / decoded-record-out bundle between the memory bus, the assembler and the FSA.
// master = bus/FSA side, slave = assembler side.
interface instr_assembler_decoder_if #(
    parameter int IMM_BYTES = 2
);
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_ready;
    logic [2:0]             flags_in;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [16:0]            dec_class;
    logic [7:0]             dec_op;
    logic [8*IMM_BYTES-1:0] dec_imm;
    logic                   dec_taken;
    logic                   dec_illegal;

    modport master (
        output byte_in, byte_valid, flags_in, dec_ready,
        input  byte_ready, dec_valid, dec_class, dec_op, dec_imm, dec_taken, dec_illegal
    );

    modport slave (
        input  byte_in, byte_valid, flags_in, dec_ready,
        output byte_ready, dec_valid, dec_class, dec_op, dec_imm, dec_taken, dec_illegal
    );
endinterface

// File: rtl/instr_assembler_decoder.sv
// Assembles 1-byte and GOTO+imm instructions, decodes class/branch, queues records (DEPTH) for the FSA.
// Latency: final byte accepted at edge N -> record at queue head after edge N when the queue was empty.
// Backpressure: final byte stalled while queue full (unless popped same edge), HALT hold; DEC_ILLEGAL_TRAP_EN adds sticky illegal trap.
module instr_assembler_decoder #(
    parameter int IMM_BYTES = 2,
    parameter int DEPTH     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    instr_assembler_decoder_if.slave bus
);
    localparam int IMM_W = 8 * IMM_BYTES;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {ST_OPC, ST_IMM} state_t;

    typedef struct packed {
        logic [16:0]      cls;
        logic [7:0]       op;
        logic [IMM_W-1:0] imm;
        logic             taken;
        logic             illegal;
    } rec_t;

    function automatic logic [16:0] classify(input logic [7:0] op);
        logic [16:0] c;
        c = '0;
        if      (op[7:6] == 2'b00)                 c[0] = 1'b1;
        else if (op[7:6] == 2'b01)                 c[2] = 1'b1;
        else if (op[7:4] == 4'b1000)               c[1] = 1'b1;
        else if (op[7:2] == 6'b100100)             c[4] = 1'b1;
        else if (op[7:2] == 6'b100110)             c[5] = 1'b1;
        else if (op == 8'hB0)                      c[3] = 1'b1;
        else if (op == 8'hAE)                      c[7] = 1'b1;
        else if (op[7:3] == 5'b10100 && !op[0])    c[6] = 1'b1;
        else if (op[7:3] == 5'b10101 && !op[0])    c[8] = 1'b1;
        else if (op[7:6] == 2'b11) begin
            // Exact variants claim their own bit and leave the general GOTO bit clear.
            case (op)
                8'hE0:   c[10] = 1'b1;
                8'hE6:   c[11] = 1'b1;
                8'hE7:   c[12] = 1'b1;
                8'hF0:   c[13] = 1'b1;
                8'hE8:   c[14] = 1'b1;
                8'hE4:   c[15] = 1'b1;
                8'hE2:   c[16] = 1'b1;
                default: c[9]  = 1'b1;
            endcase
        end
        return c;
    endfunction

    // 11dscznx; flags = {sign, carry, zero}. 0xE0 evaluates to 0, JUMP/CALL (z&n) always to 1.
    function automatic logic branch_taken(input logic [7:0] op, input logic [2:0] f);
        return (op[7:6] == 2'b11) &
               ((op[4] & f[2]) | (op[3] & ~f[1]) | (op[2] & f[0]) | (op[1] & ~f[0]));
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t           state;
    logic [2:0]       imm_cnt;
    logic [7:0]       op_reg;
    logic [IMM_W-1:0] imm_sr;
    logic [IMM_W-1:0] imm_next;
    rec_t             mem [DEPTH];
    rec_t             head;
    rec_t             rec_in;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             halt_hold;
    logic             trap;
    logic             head_vld;
    logic             full;
    logic             final_byte;
    logic             byte_rdy;
    logic             byte_fire;
    logic             push;
    logic             pop;

    assign head_vld   = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head       = mem[rd_ptr];
    assign pop        = head_vld & bus.dec_ready;
    assign final_byte = (state == ST_OPC) ? (bus.byte_in[7:6] != 2'b11)
                                          : (imm_cnt == 3'(IMM_BYTES - 1));
    // A pop in the same edge frees the slot, so a full queue only stalls when nothing drains.
    assign byte_rdy   = ~reset & ~(full & ~pop & bus.byte_valid & final_byte) & ~halt_hold & ~trap;
    assign byte_fire  = bus.byte_valid & byte_rdy;
    assign push       = byte_fire & final_byte;

    always_comb begin
        imm_next      = imm_sr << 8;
        imm_next[7:0] = bus.byte_in;
        rec_in        = '0;
        if (state == ST_OPC) begin
            rec_in.op  = bus.byte_in;
        end else begin
            rec_in.op  = op_reg;
            rec_in.imm = imm_next;
        end
        rec_in.cls     = classify(rec_in.op);
        rec_in.illegal = (rec_in.cls == '0);
        rec_in.taken   = branch_taken(rec_in.op, bus.flags_in);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_OPC;
            imm_cnt   <= '0;
            op_reg    <= '0;
            imm_sr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            halt_hold <= 1'b0;
`ifdef DEC_ILLEGAL_TRAP_EN
            trap      <= 1'b0;
`endif
        end else begin
            if (byte_fire) begin
                case (state)
                    ST_OPC: if (!final_byte) begin
                        state   <= ST_IMM;
                        op_reg  <= bus.byte_in;
                        imm_cnt <= '0;
                        imm_sr  <= '0;
                    end
                    ST_IMM: begin
                        imm_sr <= imm_next;
                        if (final_byte) state   <= ST_OPC;
                        else            imm_cnt <= imm_cnt + 3'd1;
                    end
                    default: state <= ST_OPC;
                endcase
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            // HALT is always the youngest entry while held, so its pop ends the hold.
            if (push && rec_in.cls[7])    halt_hold <= 1'b1;
            else if (pop && head.cls[7])  halt_hold <= 1'b0;
`ifdef DEC_ILLEGAL_TRAP_EN
            if (pop && head.illegal)      trap <= 1'b1;
`endif
        end
    end

`ifndef DEC_ILLEGAL_TRAP_EN
    assign trap = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= rec_in;
    end

    assign bus.byte_ready  = byte_rdy;
    assign bus.dec_valid   = head_vld;
    assign bus.dec_class   = head_vld ? head.cls     : '0;
    assign bus.dec_op      = head_vld ? head.op      : '0;
    assign bus.dec_imm     = head_vld ? head.imm     : '0;
    assign bus.dec_taken   = head_vld & head.taken;
    assign bus.dec_illegal = head_vld & head.illegal;
endmodule

// File: tb/tb_instr_assembler_decoder.sv
// Bench for instr_assembler_decoder: directed scenarios plus random instruction stream,
// scored against an instruction-level reference queue.
module tb_instr_assembler_decoder;
    localparam int IMM_BYTES = 2;
    localparam int DEPTH     = 2;
    localparam int IMM_W     = 8 * IMM_BYTES;

    localparam logic [7:0] EX_CODE [0:8] = '{8'hE0, 8'hE6, 8'hE7, 8'hF0, 8'hE8, 8'hE4, 8'hE2, 8'hB0, 8'hAE};
    localparam int         EX_BIT  [0:8] = '{10, 11, 12, 13, 14, 15, 16, 3, 7};
    localparam logic [7:0] PM_MASK [0:7] = '{8'hC0, 8'hC0, 8'hF0, 8'hFC, 8'hFC, 8'hF9, 8'hF9, 8'hC0};
    localparam logic [7:0] PM_VAL  [0:7] = '{8'h00, 8'h40, 8'h80, 8'h90, 8'h98, 8'hA0, 8'hA8, 8'hC0};
    localparam int         PM_BIT  [0:7] = '{0, 2, 1, 4, 5, 6, 8, 9};

    typedef struct {
        logic [16:0]      cls;
        logic [7:0]       op;
        logic [IMM_W-1:0] imm;
        logic             taken;
        logic             illegal;
    } rec_t;

    logic clock;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic rdy_fix;
    logic rand_mode;

    rec_t             exp_q[$];
    rec_t             mr;
    int               pend = 0;
    logic [7:0]       pend_op;
    logic [IMM_W-1:0] pend_imm;

    instr_assembler_decoder_if #(.IMM_BYTES(IMM_BYTES)) bus ();

    instr_assembler_decoder #(.IMM_BYTES(IMM_BYTES), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [16:0] ref_class(input logic [7:0] op);
        for (int i = 0; i < 9; i++) if (op == EX_CODE[i]) return 17'(1) << EX_BIT[i];
        for (int i = 0; i < 8; i++) if ((op & PM_MASK[i]) == PM_VAL[i]) return 17'(1) << PM_BIT[i];
        return '0;
    endfunction

    function automatic logic ref_taken(input logic [7:0] op, input logic [2:0] f);
        logic sgn, cy, zr;
        {sgn, cy, zr} = f;
        if (op[7:6] != 2'b11) return 1'b0;
        if (op == 8'hE0) return 1'b0;
        if (op == 8'hE6 || op == 8'hE7) return 1'b1;
        return (op[4] & sgn) | (op[3] & ~cy) | (op[2] & zr) | (op[1] & ~zr);
    endfunction

    function automatic void exp_push(input logic [7:0] op, input logic [IMM_W-1:0] imm, input logic [2:0] f);
        rec_t r;
        r.cls     = ref_class(op);
        r.op      = op;
        r.imm     = imm;
        r.taken   = ref_taken(op, f);
        r.illegal = (r.cls == '0);
        exp_q.push_back(r);
    endfunction

    // Returns 1 when the accepted byte completes an instruction.
    function automatic bit model_byte(input logic [7:0] b, input logic [2:0] f);
        if (pend == 0) begin
            if (b[7:6] == 2'b11) begin
                pend_op  = b;
                pend_imm = '0;
                pend     = IMM_BYTES;
                return 1'b0;
            end
            exp_push(b, '0, f);
            return 1'b1;
        end
        pend_imm = (pend_imm << 8) | IMM_W'(b);
        pend--;
        if (pend != 0) return 1'b0;
        exp_push(pend_op, pend_imm, f);
        return 1'b1;
    endfunction

    // Record checker: every handshake on the decoded side must match the reference head.
    always @(negedge clock) begin
        if (!reset && bus.dec_valid && bus.dec_ready) begin
            chk("rec_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mr = exp_q.pop_front();
                chk("dec_class",   bus.dec_class,   mr.cls);
                chk("dec_op",      bus.dec_op,      mr.op);
                chk("dec_imm",     bus.dec_imm,     mr.imm);
                chk("dec_taken",   bus.dec_taken,   mr.taken);
                chk("dec_illegal", bus.dec_illegal, mr.illegal);
            end
        end
    end

    initial begin
        bus.dec_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            bus.dec_ready = rand_mode ? ($urandom_range(0, 3) != 0) : rdy_fix;
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input logic [2:0] f);
        int   cyc;
        int   qb;
        logic acc;
        bit   done;
        bus.byte_in    = b;
        bus.flags_in   = f;
        bus.byte_valid = 1'b1;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 200) begin
            @(negedge clock);
            if (bus.byte_ready) acc = 1'b1;
            else cyc++;
        end
        chk("byte_accept", acc, 1'b1);
        if (acc) begin
            @(posedge clock);
            qb   = exp_q.size();
            done = model_byte(b, f);
            #1;
            if (done && qb == 0) chk("latency", bus.dec_valid, 1'b1);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.byte_valid = 1'b0;
        exp_q.delete();
        pend = 0;
        @(posedge clock);
        repeat (2) begin
            @(negedge clock);
            chk("rst_byte_ready",  bus.byte_ready,  1'b0);
            chk("rst_dec_valid",   bus.dec_valid,   1'b0);
            chk("rst_dec_class",   bus.dec_class,   17'd0);
            chk("rst_dec_op",      bus.dec_op,      8'd0);
            chk("rst_dec_imm",     bus.dec_imm,     '0);
            chk("rst_dec_taken",   bus.dec_taken,   1'b0);
            chk("rst_dec_illegal", bus.dec_illegal, 1'b0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_byte_ready", bus.byte_ready, 1'b1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        do begin
            @(posedge clock);
            cyc++;
        end while (exp_q.size() != 0 && cyc < 100);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] op;
        reset          = 1'b1;
        rdy_fix        = 1'b0;
        rand_mode      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = '0;
        bus.flags_in   = '0;
        do_reset();

        // Single-byte classes with immediate consumption.
        rdy_fix = 1'b1;
        send_byte(8'h1A, 3'b000);
        send_byte(8'h81, 3'b000);
        send_byte(8'hB0, 3'b000);
        // CALL with immediate, then BZERO with zero clear.
        send_byte(8'hE7, 3'b000);
        send_byte(8'h12, 3'b000);
        send_byte(8'h34, 3'b000);
        send_byte(8'hE4, 3'b000);
        send_byte(8'h00, 3'b110);
        send_byte(8'h00, 3'b110);
        wait_drain();

        // Full queue stalls the final byte; a same-edge pop lets it in.
        rdy_fix = 1'b0;
        send_byte(8'h00, 3'b000);
        send_byte(8'h01, 3'b000);
        bus.byte_in    = 8'h02;
        bus.byte_valid = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("full_block", bus.byte_ready, 1'b0);
            chk("head_hold",  bus.dec_op,     8'h00);
        end
        @(posedge clock); #1;
        rdy_fix = 1'b1;
        @(negedge clock);
        chk("pop_frees_slot", bus.byte_ready, 1'b1);
        @(posedge clock);
        void'(model_byte(8'h02, bus.flags_in));
        #1;
        rdy_fix        = 1'b0;
        bus.byte_in    = 8'h03;
        @(negedge clock);
        chk("full_block_again", bus.byte_ready, 1'b0);
        @(posedge clock); #1;
        rdy_fix = 1'b1;
        send_byte(8'h03, 3'b000);
        wait_drain();

        // Reset mid-immediate discards the partial GOTO.
        send_byte(8'hF0, 3'b111);
        send_byte(8'hAB, 3'b111);
        do_reset();
        rdy_fix = 1'b1;
        send_byte(8'h00, 3'b000);
        wait_drain();

        // HALT holds byte flow until it leaves the queue.
        rdy_fix = 1'b0;
        send_byte(8'hAE, 3'b000);
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("halt_hold", bus.byte_ready, 1'b0);
        end
        @(posedge clock); #1;
        rdy_fix = 1'b1;
        @(negedge clock);
        chk("halt_pop_cycle", bus.byte_ready, 1'b0);
        @(posedge clock); #1;
        send_byte(8'h00, 3'b000);
        wait_drain();

        // Illegal opcode.
        send_byte(8'hBF, 3'b000);
`ifdef DEC_ILLEGAL_TRAP_EN
        repeat (3) @(posedge clock);
        #1;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("trap_hold", bus.byte_ready, 1'b0);
        end
        do_reset();
        rdy_fix = 1'b1;
`else
        send_byte(8'h00, 3'b000);
`endif
        wait_drain();

        // Random instruction stream with random FSA backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 2))
                0:       op = 8'hC0 | 8'($urandom_range(0, 63));
                1:       op = EX_CODE[$urandom_range(0, 6)];
                default: op = 8'($urandom_range(0, 255));
            endcase
`ifdef DEC_ILLEGAL_TRAP_EN
            if (ref_class(op) == '0) op = 8'hB0;
`endif
            send_byte(op, 3'($urandom_range(0, 7)));
            if (op[7:6] == 2'b11)
                for (int k = 0; k < IMM_BYTES; k++)
                    send_byte(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
        end
        rand_mode = 1'b0;
        rdy_fix   = 1'b1;
        wait_drain();
        @(negedge clock);
        chk("end_dec_valid", bus.dec_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
